// File: rtl/imem_loader.sv
// Instruction-memory sequencer: passes CPU fetches through in RUN and, on request,
// loads a big-endian program image from a byte stream into the RAM.
module imem_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic [31:0]           cpu_pc,
    output logic [31:0]           cpu_instruction,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           word_count
);
    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] HDR_HI = 3'd1;
    localparam logic [2:0] HDR_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

    logic [2:0]    state_q, state_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [16:0]   ptr_q, ptr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          load_error_q, load_error_d;
    logic          accept;

    wire unused_pc_bits = ^{cpu_pc[31:ADDR_WIDTH+2], cpu_pc[1:0]};

    assign rx_ready        = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    assign accept          = rx_valid && rx_ready;
    assign cpu_hold        = (state_q != RUN);
    assign cpu_instruction = cpu_hold ? 32'h00000000 : mem_rd_data;
    assign mem_addr        = cpu_hold ? ptr_q[ADDR_WIDTH-1:0] : cpu_pc[ADDR_WIDTH+1:2];
    // Words beyond the RAM depth are still consumed so the stream stays aligned.
    assign mem_wr_en       = (state_q == WRITE) && (ptr_q < DEPTH);
    assign mem_wr_data     = word_q;
    assign load_done       = (state_q == FINISH);
    assign load_error      = load_error_q;
    assign word_count      = word_count_q;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        ptr_d        = ptr_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        timeout_d    = '0;
        load_error_d = load_error_q;

        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d      = HDR_HI;
                    load_error_d = 1'b0;
                    ptr_d        = '0;
                    byte_cnt_d   = '0;
                end
            end
            HDR_HI, HDR_LO, DATA: begin
                if (accept) begin
                    if (state_q == HDR_HI) begin
                        word_count_d[15:8] = rx_data;
                        state_d            = HDR_LO;
                    end else if (state_q == HDR_LO) begin
                        word_count_d[7:0] = rx_data;
                        state_d           = ({word_count_q[15:8], rx_data} == 16'd0) ? FINISH : DATA;
                    end else begin
                        word_d     = {word_q[23:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) state_d = WRITE;
                    end
                end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    load_error_d = 1'b1;
                    state_d      = RUN;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            WRITE: begin
                ptr_d   = ptr_q + 17'd1;
                state_d = ((ptr_q + 17'd1) == {1'b0, word_count_q}) ? FINISH : DATA;
            end
            FINISH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            word_count_q <= '0;
            ptr_q        <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            timeout_q    <= '0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            ptr_q        <= ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            timeout_q    <= timeout_d;
            load_error_q <= load_error_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected RAM writes go to a queue checked by a monitor.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [31:0] cpu_pc = 32'h0;
    logic [31:0] cpu_instruction;
    logic        cpu_hold;
    logic [7:0]  mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = 32'h0;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;
    logic [39:0] exp_q[$];

    imem_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_pc(cpu_pc), .cpu_instruction(cpu_instruction), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .load_done(load_done), .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, mem_addr}, 32'hFFFFFFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("write_addr", {24'h0, mem_addr}, {24'h0, e[39:32]});
                check("write_data", mem_wr_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_ready_timeout", 32'h0, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        mem_rd_data = 32'h8c850000;
        cpu_pc      = 32'h00000008;
        @(negedge clk);
        check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_load_error", {31'h0, load_error}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // RUN passthrough
        check("run_instr", cpu_instruction, 32'h8c850000);
        check("run_addr", {24'h0, mem_addr}, 32'h2);
        check("run_hold", {31'h0, cpu_hold}, 32'h0);
        check("run_wr_en", {31'h0, mem_wr_en}, 32'h0);

        // Two-word load
        pulse_start();
        check("hold_after_start", {31'h0, cpu_hold}, 32'h1);
        check("nop_during_hold", cpu_instruction, 32'h0);
        exp_q.push_back({8'd0, 32'h241d0100});
        exp_q.push_back({8'd1, 32'h24040000});
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h241d0100);
        send_word(32'h24040000);
        @(negedge clk);
        check("two_done", {31'h0, load_done}, 32'h1);
        check("two_hold_in_finish", {31'h0, cpu_hold}, 32'h1);
        check("two_count", {16'h0, word_count}, 32'd2);
        @(negedge clk);
        check("two_hold_release", {31'h0, cpu_hold}, 32'h0);
        check("two_done_pulse", {31'h0, load_done}, 32'h0);
        check("two_pending", exp_q.size(), 32'd0);

        // Empty image
        pulse_start();
        send_byte(8'h00);
        check("empty_nop", cpu_instruction, 32'h0);
        send_byte(8'h00);
        check("empty_done", {31'h0, load_done}, 32'h1);
        check("empty_nop_finish", cpu_instruction, 32'h0);
        @(negedge clk);
        check("empty_run", {31'h0, cpu_hold}, 32'h0);

        // 257 words: last one exceeds the RAM and is discarded
        pulse_start();
        for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 32'hA5000000 ^ i});
        send_byte(8'h01); send_byte(8'h01);
        for (int i = 0; i < 257; i++) begin
            w = 32'hA5000000 ^ i;
            send_word(w);
        end
        @(negedge clk);
        check("big_done", {31'h0, load_done}, 32'h1);
        check("big_error", {31'h0, load_error}, 32'h0);
        check("big_count", {16'h0, word_count}, 32'd257);
        check("big_pending", exp_q.size(), 32'd0);
        @(negedge clk);

        // Timeout after 16 idle cycles
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h24);
        repeat (15) @(negedge clk);
        check("to_not_yet", {31'h0, load_error}, 32'h0);
        check("to_still_hold", {31'h0, cpu_hold}, 32'h1);
        @(negedge clk);
        check("to_error", {31'h0, load_error}, 32'h1);
        check("to_run", {31'h0, cpu_hold}, 32'h0);
        check("to_no_done", {31'h0, load_done}, 32'h0);
        pulse_start();
        check("to_cleared", {31'h0, load_error}, 32'h0);

        // Reset mid-DATA, then a clean load with an ignored load_start
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        #2 reset = 1'b1;
        #1;
        check("arst_hold", {31'h0, cpu_hold}, 32'h0);
        check("arst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("arst_count", {16'h0, word_count}, 32'h0);
        check("arst_wr_en", {31'h0, mem_wr_en}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        exp_q.push_back({8'd0, 32'hCAFEF00D});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA);
        pulse_start();
        send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        @(negedge clk);
        check("rst_load_done", {31'h0, load_done}, 32'h1);
        check("rst_load_count", {16'h0, word_count}, 32'd1);
        @(negedge clk);
        check("rst_load_run", {31'h0, cpu_hold}, 32'h0);
        check("rst_load_pending", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequences the writable instruction memory (256 x 32-bit words, indexed by PC[9:2]).
- In RUN, forwards CPU fetches to the memory.
- After a load_start pulse, holds the CPU, receives a program image as a byte stream from the UART receiver, assembles big-endian words and writes them from word 0 upward, then releases the CPU.
- Sits between the UART RX, the CPU fetch stage and the instruction RAM.

Parameters:
ADDR_WIDTH, 8, word-address width; memory depth = 2**ADDR_WIDTH words
TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes while loading before abort

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_start  input  1  one-cycle request to begin a program load
rx_valid  input  1  rx_data holds a byte
rx_data  input  8  received byte
rx_ready  output  1  byte accepted on rx_valid && rx_ready
cpu_pc  input  32  fetch address from CPU
cpu_instruction  output  32  instruction to CPU
cpu_hold  output  1  CPU held in reset/stall while high
mem_addr  output  ADDR_WIDTH  RAM word address
mem_wr_en  output  1  RAM write strobe, synchronous write
mem_wr_data  output  32  RAM write data
mem_rd_data  input  32  RAM combinational read data
load_done  output  1  one-cycle pulse when a load completes successfully
load_error  output  1  sticky; set on timeout, cleared by next accepted load_start
word_count  output  16  header word count of the last load

Behaviour:
- Reset values: state RUN; rx_ready, cpu_hold, mem_wr_en, load_done, load_error all 0; word_count 0; byte/word counters 0; timeout counter 0. Reset mid-load aborts immediately to RUN. Words already written stay in RAM.
- Clock: clk only. Reset is asynchronous and active-high on port reset.
- States: RUN, HDR_HI, HDR_LO, DATA, WRITE, FINISH.
- RUN:
  - mem_addr = cpu_pc[ADDR_WIDTH+1:2]; cpu_instruction = mem_rd_data (combinational, zero latency); rx_ready=0; cpu_hold=0.
  - load_start -> HDR_HI; clear load_error, word pointer and byte counter; cpu_hold rises the next cycle.
- Any state other than RUN:
  - cpu_hold=1; cpu_instruction=32'h00000000 (nop).
  - mem_addr = write word pointer.
  - load_start is ignored.
- HDR_HI / HDR_LO: rx_ready=1. Accepted byte becomes word_count[15:8] / [7:0]. From HDR_LO: count 0 -> FINISH, else -> DATA.
- DATA:
  - rx_ready=1; bytes are shifted in MSB-first.
  - After the 4th byte is accepted -> WRITE.
- WRITE:
  - rx_ready=0; mem_wr_en=1 for exactly one cycle, at the assembled word and current pointer.
  - Writes are suppressed when pointer >= 2**ADDR_WIDTH; excess words are consumed but discarded, with no error.
  - Pointer (17-bit internal) increments. If words received == word_count -> FINISH, else -> DATA.
- FINISH: one cycle; load_done=1, cpu_hold still 1; -> RUN. cpu_hold falls the cycle after FINISH, so the CPU restarts from PC 0 after reset release by the CPU.
- Timeout:
  - In HDR_HI, HDR_LO or DATA, the counter increments each cycle without an accepted byte and clears on acceptance.
  - Reaching TIMEOUT_CYCLES -> load_error=1, go to RUN directly (no load_done).
- Simultaneous rx_valid and timeout expiry: the byte is accepted and the counter clears.
- rx_data is sampled only when rx_valid && rx_ready. Bytes arriving in RUN or WRITE are not accepted; the UART must hold them.

Test Plan:
- Reset, then cpu_pc=0x00000008 with mem_rd_data=0x8c850000 -> cpu_instruction=0x8c850000 same cycle; cpu_hold=0; mem_wr_en=0.
- load_start, then bytes 00 02 24 1d 01 00 24 04 00 00 -> writes 0x241d0100 @0 and 0x24040000 @1, one mem_wr_en cycle each; load_done pulse; word_count=2; cpu_hold low one cycle after FINISH.
- Header 00 00 -> no writes; load_done the cycle after HDR_LO accept; cpu_instruction=0 throughout hold.
- Header 01 01 (257 words) with ADDR_WIDTH=8 -> 256 writes (addr 0..255); 257th word consumed with mem_wr_en=0; load_done=1, load_error=0.
- TIMEOUT_CYCLES=16; send 00 01 24 then stall -> load_error=1 after 16 idle cycles; no write; back to RUN; next load_start clears load_error.
- Assert reset during DATA after 2 bytes -> all outputs at reset values asynchronously; next load restarts from HDR_HI at word 0; load_start pulsed mid-load is ignored.
